// File: rtl/conv2d_ofm_writer_if.sv
// ----------------------------------------------------------------------------
// conv2d_ofm_writer_if
//   Bundles the control, compute-side and memory-side signals of the OFM
//   writer into one interface.
//
//   Control : start, idle, done, overflow, ofm_base, fm_dim
//   Compute : wdata, wdata_valid (no back-pressure path)
//   Memory  : mem_waddr, mem_wdata, mem_wvalid, mem_wready
//
//   Modports
//     slave  - the writer itself (drives idle/done/overflow/mem_*)
//     master - the surrounding system or testbench
// ----------------------------------------------------------------------------
interface conv2d_ofm_writer_if #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
);
    logic              start;
    logic              idle;
    logic              done;
    logic [AWIDTH-1:0] ofm_base;
    logic [31:0]       fm_dim;
    logic [DWIDTH-1:0] wdata;
    logic              wdata_valid;
    logic [AWIDTH-1:0] mem_waddr;
    logic [DWIDTH-1:0] mem_wdata;
    logic              mem_wvalid;
    logic              mem_wready;
    logic              overflow;

    modport slave (
        input  start, ofm_base, fm_dim, wdata, wdata_valid, mem_wready,
        output idle, done, mem_waddr, mem_wdata, mem_wvalid, overflow
    );

    modport master (
        output start, ofm_base, fm_dim, wdata, wdata_valid, mem_wready,
        input  idle, done, mem_waddr, mem_wdata, mem_wvalid, overflow
    );
endinterface

// File: rtl/conv2d_ofm_writer.sv
// ----------------------------------------------------------------------------
// conv2d_ofm_writer
//   Streams output-feature-map words from the compute unit into data memory.
//   Words are buffered in a small FIFO and written to consecutive 32-bit
//   word addresses starting at ofm_base, fm_dim*fm_dim words per pass.
//
//   Ports
//     clk  - single clock, rising edge
//     rst  - synchronous active-high reset
//     bus  - conv2d_ofm_writer_if.slave (control, compute stream, memory
//            write channel; see the interface file)
//
//   Parameters
//     AWIDTH     - memory byte-address width
//     DWIDTH     - OFM word width
//     FIFO_DEPTH - buffer entries, power of two, >= 2
//
//   Build option
//     CONV2D_OFM_RELU_EN - when defined, negative head words are written as
//                          zero (ReLU on the memory side of the FIFO).
// ----------------------------------------------------------------------------
module conv2d_ofm_writer #(
    parameter int AWIDTH     = 32,
    parameter int DWIDTH     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    conv2d_ofm_writer_if.slave   bus
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [31:0]       index_q;
    logic [31:0]       index_d;
    logic [AWIDTH-1:0] ofmBase_q;
    logic [31:0]       fmDim_q;
    logic              overflow_q;

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    logic [PTR_W:0]    wrPtr_q;
    logic [PTR_W:0]    wrPtr_d;
    logic [PTR_W:0]    rdPtr_q;
    logic [PTR_W:0]    rdPtr_d;
    logic [DWIDTH-1:0] fifoMem_q [FIFO_DEPTH];

    logic              fifoEmpty;
    logic              fifoFull;
    logic              startAccept;
    logic              fire;
    logic              push;
    logic              drop;
    logic [31:0]       lastIdx;
    logic [31:0]       byteOffset;
    logic [DWIDTH-1:0] headWord;
    logic [DWIDTH-1:0] outWord;

    assign fifoEmpty = (wrPtr_q == rdPtr_q);
    assign fifoFull  = (wrPtr_q[PTR_W] != rdPtr_q[PTR_W]) &&
                       (wrPtr_q[PTR_W-1:0] == rdPtr_q[PTR_W-1:0]);

    assign startAccept = (state_q == IDLE) && bus.start;
    assign fire        = bus.mem_wvalid && bus.mem_wready;

    // A full FIFO can still take a word when the head leaves in the same cycle.
    assign push = (state_q != IDLE) && bus.wdata_valid && (!fifoFull || fire);
    assign drop = (state_q != IDLE) && bus.wdata_valid && fifoFull && !fire;

    // Index of the final word of the pass; only meaningful when fm_dim != 0.
    assign lastIdx    = fmDim_q * fmDim_q - 32'd1;
    assign byteOffset = {index_q[29:0], 2'b00};

    assign headWord = fifoMem_q[rdPtr_q[PTR_W-1:0]];

`ifdef CONV2D_OFM_RELU_EN
    assign outWord = headWord[DWIDTH-1] ? '0 : headWord;
`else
    assign outWord = headWord;
`endif

    // Memory-side outputs depend only on registered state, so address and
    // data stay put for as long as a request is stalled.
    assign bus.mem_wvalid = (state_q == RUN) && !fifoEmpty;
    assign bus.mem_wdata  = fifoEmpty ? '0 : outWord;
    assign bus.mem_waddr  = ofmBase_q + AWIDTH'(byteOffset);
    assign bus.idle       = (state_q == IDLE);
    assign bus.done       = (state_q == DONE);
    assign bus.overflow   = overflow_q;

    // Next pointer / index values.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        index_d = index_q;
        if (push) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end
        if (fire) begin
            rdPtr_d = rdPtr_q + 1'b1;
        end
        if (startAccept) begin
            index_d = '0;
        end else if (fire) begin
            index_d = index_q + 32'd1;
        end
    end

    // Pass sequencing, captured pass parameters, FIFO pointers and the
    // sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            index_q    <= '0;
            ofmBase_q  <= '0;
            fmDim_q    <= '0;
            overflow_q <= 1'b0;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            index_q <= index_d;

            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q   <= RUN;
                        ofmBase_q <= bus.ofm_base;
                        fmDim_q   <= bus.fm_dim;
                    end
                end
                RUN: begin
                    // A zero-sized map finishes immediately without writing.
                    if ((fmDim_q == 32'd0) || (fire && (index_q == lastIdx))) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase

            if (startAccept) begin
                overflow_q <= 1'b0;
            end else if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // FIFO storage needs no reset: entries are only read when the FIFO
    // is non-empty.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifoMem_q[wrPtr_q[PTR_W-1:0]] <= bus.wdata;
        end
    end

endmodule

// File: tb/tb_conv2d_ofm_writer.sv
// ----------------------------------------------------------------------------
// tb_conv2d_ofm_writer
//   Directed testbench for conv2d_ofm_writer (default parameters,
//   FIFO_DEPTH = 4). Expected values are hand-computed constants.
//   The ReLU expectation follows CONV2D_OFM_RELU_EN when it is defined.
// ----------------------------------------------------------------------------
module tb_conv2d_ofm_writer;

    logic clk;
    logic rst;
    int   assertCount;
    int   failCount;
    logic [31:0] reluExpected;

    conv2d_ofm_writer_if #(.AWIDTH(32), .DWIDTH(32)) bus ();

    conv2d_ofm_writer #(
        .AWIDTH    (32),
        .DWIDTH    (32),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle's worth of inputs, then advance to just after the next
    // rising edge so the registered outputs can be sampled.
    task automatic applyStimulus(input logic st, input logic [31:0] base,
                                 input logic [31:0] dim, input logic [31:0] wd,
                                 input logic wv, input logic rdy);
        bus.start       = st;
        bus.ofm_base    = base;
        bus.fm_dim      = dim;
        bus.wdata       = wd;
        bus.wdata_valid = wv;
        bus.mem_wready  = rdy;
        @(posedge clk);
        #1;
    endtask

    // Compare one observed value with its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Directed sequence covering the main pass, stalls, overflow, reset
    // mid-pass, ReLU and the zero-sized map.
    initial begin
        assertCount = 0;
        failCount   = 0;
`ifdef CONV2D_OFM_RELU_EN
        reluExpected = 32'h0000_0000;
`else
        reluExpected = 32'hFFFF_FFFB;
`endif
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        rst = 1'b0;

        $display("[TB] reset values");
        checkOutput("rst_idle",     32'(bus.idle),       32'd1);
        checkOutput("rst_done",     32'(bus.done),       32'd0);
        checkOutput("rst_wvalid",   32'(bus.mem_wvalid), 32'd0);
        checkOutput("rst_overflow", 32'(bus.overflow),   32'd0);
        checkOutput("rst_waddr",    bus.mem_waddr,       32'h0);
        checkOutput("rst_wdata",    bus.mem_wdata,       32'h0);

        $display("[TB] basic 2x2 pass at 0x1000");
        applyStimulus(1, 32'h1000, 2, 0, 0, 1);
        checkOutput("p1_run_idle", 32'(bus.idle), 32'd0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 32'h1000, 2, 32'(i + 1), 1, 1);
            checkOutput("p1_wvalid", 32'(bus.mem_wvalid), 32'd1);
            checkOutput("p1_waddr",  bus.mem_waddr, 32'h1000 + 32'(4 * i));
            checkOutput("p1_wdata",  bus.mem_wdata, 32'(i + 1));
        end
        applyStimulus(0, 32'h1000, 2, 0, 0, 1);
        checkOutput("p1_done",        32'(bus.done),       32'd1);
        checkOutput("p1_done_wvalid", 32'(bus.mem_wvalid), 32'd0);
        applyStimulus(0, 32'h1000, 2, 0, 0, 1);
        checkOutput("p1_end_done", 32'(bus.done), 32'd0);
        checkOutput("p1_end_idle", 32'(bus.idle), 32'd1);

        $display("[TB] 3 words under a 10-cycle stall");
        applyStimulus(1, 32'h3000, 2, 0, 0, 0);
        applyStimulus(0, 32'h3000, 2, 32'h11, 1, 0);
        applyStimulus(0, 32'h3000, 2, 32'h22, 1, 0);
        applyStimulus(0, 32'h3000, 2, 32'h33, 1, 0);
        applyStimulus(1, 32'h9000, 5, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 32'h3000, 2, 0, 0, 0);
        end
        checkOutput("p2_overflow", 32'(bus.overflow),   32'd0);
        checkOutput("p2_wvalid",   32'(bus.mem_wvalid), 32'd1);
        checkOutput("p2_waddr0",   bus.mem_waddr,       32'h3000);
        checkOutput("p2_wdata0",   bus.mem_wdata,       32'h11);
        applyStimulus(0, 32'h3000, 2, 0, 0, 1);
        checkOutput("p2_waddr1", bus.mem_waddr, 32'h3004);
        checkOutput("p2_wdata1", bus.mem_wdata, 32'h22);
        applyStimulus(0, 32'h3000, 2, 0, 0, 1);
        checkOutput("p2_waddr2", bus.mem_waddr, 32'h3008);
        checkOutput("p2_wdata2", bus.mem_wdata, 32'h33);
        applyStimulus(0, 32'h3000, 2, 0, 0, 1);
        checkOutput("p2_empty_wvalid", 32'(bus.mem_wvalid), 32'd0);
        checkOutput("p2_not_done",     32'(bus.done),       32'd0);
        applyStimulus(0, 32'h3000, 2, 32'h44, 1, 1);
        checkOutput("p2_waddr3", bus.mem_waddr, 32'h300C);
        checkOutput("p2_wdata3", bus.mem_wdata, 32'h44);
        applyStimulus(0, 32'h3000, 2, 0, 0, 1);
        checkOutput("p2_done", 32'(bus.done), 32'd1);
        applyStimulus(0, 32'h3000, 2, 0, 0, 1);
        checkOutput("p2_idle", 32'(bus.idle), 32'd1);

        $display("[TB] full FIFO: push with pop, then overflow");
        applyStimulus(1, 32'h4000, 3, 0, 0, 0);
        applyStimulus(0, 32'h4000, 3, 32'hB1, 1, 0);
        applyStimulus(0, 32'h4000, 3, 32'hB2, 1, 0);
        applyStimulus(0, 32'h4000, 3, 32'hB3, 1, 0);
        applyStimulus(0, 32'h4000, 3, 32'hB4, 1, 0);
        checkOutput("p3_full_overflow", 32'(bus.overflow), 32'd0);
        checkOutput("p3_head_b1",       bus.mem_wdata,     32'hB1);
        applyStimulus(0, 32'h4000, 3, 32'hB5, 1, 1);
        checkOutput("p3_pushpop_overflow", 32'(bus.overflow), 32'd0);
        checkOutput("p3_head_b2",          bus.mem_wdata,     32'hB2);
        applyStimulus(0, 32'h4000, 3, 32'hB6, 1, 0);
        checkOutput("p3_drop_overflow", 32'(bus.overflow), 32'd1);
        checkOutput("p3_stall_waddr",   bus.mem_waddr,     32'h4004);
        checkOutput("p3_stall_wdata",   bus.mem_wdata,     32'hB2);
        applyStimulus(0, 32'h4000, 3, 0, 0, 1);
        checkOutput("p3_waddr_b3", bus.mem_waddr, 32'h4008);
        checkOutput("p3_wdata_b3", bus.mem_wdata, 32'hB3);
        applyStimulus(0, 32'h4000, 3, 0, 0, 1);
        checkOutput("p3_waddr_b4", bus.mem_waddr, 32'h400C);
        checkOutput("p3_wdata_b4", bus.mem_wdata, 32'hB4);
        applyStimulus(0, 32'h4000, 3, 0, 0, 1);
        checkOutput("p3_waddr_b5", bus.mem_waddr, 32'h4010);
        checkOutput("p3_wdata_b5", bus.mem_wdata, 32'hB5);
        applyStimulus(0, 32'h4000, 3, 0, 0, 1);
        checkOutput("p3_drained_wvalid", 32'(bus.mem_wvalid), 32'd0);
        checkOutput("p3_sticky_overflow", 32'(bus.overflow),  32'd1);
        checkOutput("p3_still_running",  32'(bus.idle),       32'd0);

        $display("[TB] reset mid-pass, restart at 0x2000");
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 1);
        rst = 1'b0;
        checkOutput("p4_rst_overflow", 32'(bus.overflow), 32'd0);
        applyStimulus(1, 32'h5000, 2, 0, 0, 1);
        applyStimulus(0, 32'h5000, 2, 32'hC1, 1, 1);
        checkOutput("p4_waddr_c1", bus.mem_waddr, 32'h5000);
        applyStimulus(0, 32'h5000, 2, 32'hC2, 1, 1);
        checkOutput("p4_waddr_c2", bus.mem_waddr, 32'h5004);
        applyStimulus(0, 32'h5000, 2, 0, 0, 1);
        applyStimulus(0, 32'h5000, 2, 32'hC3, 1, 1);
        checkOutput("p4_waddr_c3", bus.mem_waddr, 32'h5008);
        rst = 1'b1;
        applyStimulus(1, 32'h7000, 3, 32'hC4, 1, 1);
        rst = 1'b0;
        checkOutput("p4_rst_idle",   32'(bus.idle),       32'd1);
        checkOutput("p4_rst_wvalid", 32'(bus.mem_wvalid), 32'd0);
        checkOutput("p4_rst_waddr",  bus.mem_waddr,       32'h0);
        checkOutput("p4_rst_wdata",  bus.mem_wdata,       32'h0);
        applyStimulus(0, 32'h7000, 3, 0, 0, 1);
        checkOutput("p4_start_ignored_by_rst", 32'(bus.idle), 32'd1);
        applyStimulus(1, 32'h2000, 1, 0, 0, 1);
        applyStimulus(0, 32'h2000, 1, 32'hD1, 1, 1);
        checkOutput("p4_new_waddr", bus.mem_waddr, 32'h2000);
        checkOutput("p4_new_wdata", bus.mem_wdata, 32'hD1);
        applyStimulus(0, 32'h2000, 1, 0, 0, 1);
        checkOutput("p4_done", 32'(bus.done), 32'd1);
        applyStimulus(0, 32'h2000, 1, 0, 0, 1);
        checkOutput("p4_idle", 32'(bus.idle), 32'd1);

        $display("[TB] idle ignores data, negative word, zero-sized map");
        applyStimulus(0, 32'h6000, 1, 32'hDEAD, 1, 1);
        checkOutput("p5_idle_wvalid", 32'(bus.mem_wvalid), 32'd0);
        applyStimulus(1, 32'h6000, 1, 32'hBEEF, 1, 1);
        checkOutput("p5_run_empty_wvalid", 32'(bus.mem_wvalid), 32'd0);
        applyStimulus(0, 32'h6000, 1, 32'hFFFF_FFFB, 1, 1);
        checkOutput("p5_neg_waddr", bus.mem_waddr, 32'h6000);
        checkOutput("p5_neg_wdata", bus.mem_wdata, reluExpected);
        applyStimulus(0, 32'h6000, 1, 0, 0, 1);
        checkOutput("p5_done", 32'(bus.done), 32'd1);
        applyStimulus(0, 32'h6000, 1, 0, 0, 1);
        applyStimulus(1, 32'h6000, 0, 0, 0, 1);
        checkOutput("p6_zero_run_idle", 32'(bus.idle), 32'd0);
        checkOutput("p6_zero_run_done", 32'(bus.done), 32'd0);
        applyStimulus(0, 32'h6000, 0, 0, 0, 1);
        checkOutput("p6_zero_done",        32'(bus.done),       32'd1);
        checkOutput("p6_zero_done_wvalid", 32'(bus.mem_wvalid), 32'd0);
        applyStimulus(0, 32'h6000, 0, 0, 0, 1);
        checkOutput("p6_zero_idle", 32'(bus.idle), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
